// File: rtl/pacman_soc_pio_pkg.sv
// Shared definitions for the pacman SoC PIO blocks: Avalon register
// offsets and the edge-capture mode encodings.
package pacman_soc_pio_pkg;

    // Word offsets on the Avalon-MM slave port
    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK  = 2'd1;
    localparam logic [1:0] ADDR_RESERVED = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP  = 2'd3;

    // EDGE_TYPE parameter encodings
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage : pacman_soc_pio_pkg

// File: rtl/pacman_soc_sync_bus.sv
// WIDTH-bit multi-flop synchronizer bringing asynchronous status inputs
// into the clk domain. Synchronous active-high reset clears every stage.
module pacman_soc_sync_bus #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;
    logic [STAGES-1:0][WIDTH-1:0] stage_d;

    // Next state of the shift chain: the raw input enters stage 0.
    // NOTE: every element is assigned on every pass, so no latch is inferred.
    always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Shift register flops.
    // NOTE: non-blocking assignments so every stage samples the pre-edge value.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[STAGES-1];

endmodule : pacman_soc_sync_bus

// File: rtl/pacman_soc_vga_status_pio.sv
// Avalon-MM input PIO for VGA/game status flags: synchronizes the inputs,
// captures edges into a write-1-to-clear register and raises a level irq
// for any captured bit that is enabled in IRQMASK. Read latency is 1.
module pacman_soc_vga_status_pio
    import pacman_soc_pio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    // The arm counter covers the synchronizer fill plus the prev_q stage, so
    // inputs already high at reset release never look like a fresh edge.
    localparam logic [2:0] ARM_LAST = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] clr_mask;
    logic [2:0]       arm_cnt_q, arm_cnt_d;
    logic             armed_q, armed_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr_en;

    pacman_soc_sync_bus #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (in_port),
        .q     (sync_q)
    );

    assign wr_en = chipselect & ~write_n;

    // Edge detector selected at elaboration time by EDGE_TYPE.
    always_comb begin
        case (EDGE_TYPE)
            EDGE_FALLING: edge_det = ~sync_q & prev_q;
            EDGE_ANY:     edge_det = sync_q ^ prev_q;
            default:      edge_det = sync_q & ~prev_q;
        endcase
    end

    // Arm counter: saturates after the synchronizer has flushed, then arms.
    always_comb begin
        arm_cnt_d = arm_cnt_q;
        if (arm_cnt_q != ARM_LAST) begin
            arm_cnt_d = arm_cnt_q + 3'd1;
        end
        armed_d = armed_q | (arm_cnt_d == ARM_LAST);
    end

    // Register next-state: IRQMASK write, EDGECAP set-over-clear, prev tap.
    always_comb begin
        prev_d    = sync_q;
        irqmask_d = irqmask_q;
        clr_mask  = '0;
        if (wr_en && address == ADDR_IRQMASK) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == ADDR_EDGECAP) begin
            clr_mask = writedata[WIDTH-1:0];
        end
        // A new edge wins over a simultaneous clear so no event is lost.
        edgecap_d = (edgecap_q & ~clr_mask) | (edge_det & {WIDTH{armed_q}});
    end

    // Read mux; chipselect deliberately does not gate the read path.
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:    readdata_d[WIDTH-1:0] = sync_q;
            ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
            ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
            default:      readdata_d = '0;
        endcase
    end

    // All state flops, cleared together by the synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q     <= '0;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            arm_cnt_q  <= '0;
            armed_q    <= 1'b0;
            readdata_q <= '0;
        end else begin
            prev_q     <= prev_d;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            arm_cnt_q  <= arm_cnt_d;
            armed_q    <= armed_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edgecap_q & irqmask_q);

endmodule : pacman_soc_vga_status_pio

// File: tb/tb_pacman_soc_vga_status_pio.sv
// Self-checking bench: one rising-edge instance (u0) and one any-edge
// instance (u1) share clock, reset and bus lines; chipselect picks the target.
module tb_pacman_soc_vga_status_pio;
    import pacman_soc_pio_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        write_n;
    logic [31:0] writedata;
    logic        cs0, cs1;
    logic [31:0] in0, in1;
    logic [31:0] rd0, rd1;
    logic        irq0, irq1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        int          unit;
        logic [31:0] exp;
    } rd_exp_t;

    rd_exp_t sb_q[$];

    always #5 clk = ~clk;

    pacman_soc_vga_status_pio #(
        .WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_RISING)
    ) u0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs0),
        .write_n(write_n), .writedata(writedata), .readdata(rd0),
        .in_port(in0), .irq(irq0)
    );

    pacman_soc_vga_status_pio #(
        .WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_ANY)
    ) u1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs1),
        .write_n(write_n), .writedata(writedata), .readdata(rd1),
        .in_port(in1), .irq(irq1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_irq(input string tag, input int unit, input logic exp);
        logic got;
        got = (unit == 0) ? irq0 : irq1;
        check(tag, {31'd0, got}, {31'd0, exp});
    endtask

    // Single-cycle write, issued at a negedge and sampled on the next posedge.
    task automatic bus_write(input int unit, input logic [1:0] addr, input logic [31:0] data);
        address   = addr;
        writedata = data;
        write_n   = 1'b0;
        cs0       = (unit == 0);
        cs1       = (unit == 1);
        @(negedge clk);
        write_n   = 1'b1;
        cs0       = 1'b0;
        cs1       = 1'b0;
    endtask

    // Read: expectation queued when the address is driven, popped and
    // compared once readdata is valid after the sampling edge.
    task automatic bus_read(input int unit, input logic [1:0] addr, input logic [31:0] exp,
                            input string tag);
        rd_exp_t e;
        address = addr;
        write_n = 1'b1;
        e.tag  = tag;
        e.unit = unit;
        e.exp  = exp;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check(e.tag, (e.unit == 0) ? rd0 : rd1, e.exp);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        address   = ADDR_DATA;
        write_n   = 1'b1;
        writedata = '0;
        cs0       = 1'b0;
        cs1       = 1'b0;
        in0       = 32'hFFFF_FFFF;
        in1       = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_readdata", rd0, 32'h0);
        chk_irq("rst_irq", 0, 1'b0);
        reset = 1'b0;

        // DATA after release with all inputs high
        for (int i = 0; i < 8; i++) begin
            if (i == 0)
                bus_read(0, ADDR_DATA, 32'h0, "data_first_read");
            else if (i >= 3)
                bus_read(0, ADDR_DATA, 32'hFFFF_FFFF, "data_after_sync");
            else
                @(negedge clk);
        end

        // No spurious capture from inputs high at release
        for (int i = 0; i < 20; i++) begin
            bus_read(0, ADDR_EDGECAP, 32'h0, "no_spurious_cap");
            chk_irq("no_spurious_irq", 0, 1'b0);
        end

        // Falling edges are ignored by the rising-edge instance
        in0 = 32'h0;
        repeat (5) @(negedge clk);
        bus_read(0, ADDR_EDGECAP, 32'h0, "rise_only_ignores_fall");
        bus_read(0, ADDR_DATA, 32'h0, "data_low");

        // Rising edge on bit 0 with IRQMASK=1: irq after exactly 3 edges
        bus_write(0, ADDR_IRQMASK, 32'h1);
        bus_read(0, ADDR_IRQMASK, 32'h1, "irqmask_readback");
        in0[0] = 1'b1;
        for (int e = 0; e < 3; e++) begin
            @(posedge clk);
            #1;
            chk_irq($sformatf("rise_irq_edge%0d", e), 0, (e == 2));
        end
        @(negedge clk);
        bus_read(0, ADDR_EDGECAP, 32'h1, "edgecap_bit0");
        chk_irq("irq_before_clear", 0, 1'b1);
        bus_write(0, ADDR_EDGECAP, 32'h1);
        chk_irq("irq_after_clear", 0, 1'b0);
        bus_read(0, ADDR_EDGECAP, 32'h0, "edgecap_cleared");

        // Edge on bit 4 in the same cycle as a W1C of bit 4
        in0[4] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus_write(0, ADDR_EDGECAP, 32'h10);
        bus_read(0, ADDR_EDGECAP, 32'h10, "set_beats_clear");
        bus_write(0, ADDR_EDGECAP, 32'h10);
        bus_read(0, ADDR_EDGECAP, 32'h0, "bit4_cleared_later");

        // Mask gating
        bus_write(0, ADDR_IRQMASK, 32'h0);
        in0[2] = 1'b1;
        in0[5] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_irq("masked_irq_low", 0, 1'b0);
        end
        bus_read(0, ADDR_EDGECAP, 32'h24, "edgecap_bits_2_5");
        bus_write(0, ADDR_IRQMASK, 32'h20);
        chk_irq("unmask_irq_high", 0, 1'b1);
        bus_write(0, ADDR_EDGECAP, 32'h20);
        chk_irq("clear_bit5_irq_low", 0, 1'b0);
        bus_read(0, ADDR_EDGECAP, 32'h04, "edgecap_bit2_left");

        // Any-edge instance: 2-cycle pulse on bit 7, cleared between edges
        bus_write(1, ADDR_IRQMASK, 32'h80);
        in1[7] = 1'b1;
        @(posedge clk); #1; chk_irq("any_e0", 1, 1'b0);
        @(negedge clk);
        @(posedge clk); #1; chk_irq("any_e1", 1, 1'b0);
        @(negedge clk);
        in1[7] = 1'b0;
        @(posedge clk); #1; chk_irq("any_rise_captured", 1, 1'b1);
        @(negedge clk);
        address   = ADDR_EDGECAP;
        writedata = 32'h80;
        write_n   = 1'b0;
        cs1       = 1'b1;
        @(posedge clk); #1; chk_irq("any_cleared", 1, 1'b0);
        @(negedge clk);
        write_n = 1'b1;
        cs1     = 1'b0;
        @(posedge clk); #1; chk_irq("any_fall_recaptured", 1, 1'b1);
        @(negedge clk);
        bus_read(1, ADDR_EDGECAP, 32'h80, "any_edgecap_bit7");

        // Reserved offset and ignored DATA write
        bus_write(0, ADDR_RESERVED, 32'hDEAD_BEEF);
        bus_write(0, ADDR_DATA, 32'hFFFF_FFFF);
        bus_read(0, ADDR_RESERVED, 32'h0, "reserved_reads_0");
        bus_read(0, ADDR_DATA, 32'h35, "data_unchanged");
        bus_read(0, ADDR_IRQMASK, 32'h20, "irqmask_unchanged");
        bus_read(0, ADDR_EDGECAP, 32'h04, "edgecap_unchanged");

        // Mid-operation reset with an interrupt pending
        bus_write(0, ADDR_IRQMASK, 32'h04);
        chk_irq("pending_irq_high", 0, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk_irq("reset_irq_low", 0, 1'b0);
        chk_irq("reset_irq1_low", 1, 1'b0);
        check("reset_readdata", rd0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        bus_read(0, ADDR_IRQMASK, 32'h0, "post_reset_irqmask");
        bus_read(0, ADDR_EDGECAP, 32'h0, "post_reset_edgecap");
        bus_read(1, ADDR_EDGECAP, 32'h0, "post_reset_edgecap_u1");
        repeat (10) @(negedge clk);
        bus_read(0, ADDR_EDGECAP, 32'h0, "rearm_no_spurious");
        bus_read(0, ADDR_DATA, 32'h35, "post_reset_data");
        chk_irq("post_reset_irq", 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pacman_soc_vga_status_pio

// File: doc/pacman_soc_vga_status_pio.md
# pacman_soc_vga_status_pio

Avalon-MM slave input port with edge capture and interrupt generation. It is the CPU-facing reader for status signals driven by the VGA/game hardware, such as vsync, frame-done and sprite-collision flags. It carries those signals back to the Nios II. It pairs with the existing output PIOs that drive VGA pixel/control values, and sits on the same Avalon bus, with the same register-offset scheme.

## Interface
Parameters:
- WIDTH, 32: number of input bits, 1..32.
- SYNC_STAGES, 2: synchronizer flops per bit, 2..4.
- EDGE_TYPE, 0: which edges are captured. 0 = rising, 1 = falling, 2 = any.

Ports:
- clk  in  1  system clock; every flop is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  registered read data; read latency is 1.
- in_port  in  WIDTH  asynchronous status inputs from the VGA/game logic.
- irq  out  1  level interrupt to the CPU, active-high.

## Operation
Register map (word offsets):
- 0, DATA, read-only: the synchronized in_port value, zero-extended. Writes are ignored.
- 1, IRQMASK, read/write: bits [WIDTH-1:0]. Upper bits read as 0.
- 2, reserved: reads 0, writes are ignored.
- 3, EDGECAP, read / write-1-to-clear: a write clears every bit that is 1 in writedata[WIDTH-1:0].

Synchronizer:
- SYNC_STAGES-deep shift register per bit.
- sync_q is the last stage.
- prev_q is sync_q delayed by one cycle.

Edge detection:
- Rising: sync_q & ~prev_q. Falling: ~sync_q & prev_q. Any: sync_q ^ prev_q.
- Detection is gated by an arm counter. After reset it counts SYNC_STAGES+1 cycles and then asserts armed, which stays set until the next reset.
- Inputs that are already asserted when reset releases therefore produce no spurious capture.

EDGECAP bit update, per cycle, in priority order:
- Detected edge while armed → set to 1.
- Otherwise, a W1C write with that bit of writedata = 1 → clear to 0.
- Otherwise → hold.
- An edge in the same cycle as a clear of the same bit leaves the bit set, so no event is lost.

Interrupt:
- irq = |(EDGECAP & IRQMASK), driven combinationally from registers only.
- Writing IRQMASK immediately re-evaluates irq against any captures already pending.

Read path:
- Every cycle, readdata is registered with the mux output selected by address. chipselect does not gate the read.
- The interconnect is configured with readLatency = 1.

Reset values:
- All synchronizer flops, prev_q, IRQMASK, EDGECAP, the arm counter and readdata are 0.
- armed is 0, so irq = 0.
- A reset mid-operation discards pending captures and the mask.

## Timing
Input-to-visible latency, with in_port changing before clock edge 0:
- sync_q updates at edge SYNC_STAGES-1. DATA readdata reflects it one edge later.
- The EDGECAP bit sets at edge SYNC_STAGES, and irq rises in the same cycle if the bit is masked in.
- With SYNC_STAGES=2: EDGECAP is set and irq is high after the 3rd edge.

Bus timing:
- Write: takes effect at the clock edge on which chipselect && !write_n is sampled. No wait states.
- Read: address sampled at edge k gives readdata valid after edge k.
- Back-to-back reads are allowed every cycle.

Interrupt clear:
- A W1C clear of the last pending masked bit drops irq in the cycle after that write edge.
- irq never glitches, because it depends only on flop outputs.

Pulses:
- A pulse on in_port shorter than one clk period may be missed. This is acceptable.
- Pulses of two or more cycles are always captured once armed.

## Structure
- Shared package pacman_soc_pio_pkg holds:
  - the register offset constants ADDR_DATA=0, ADDR_IRQMASK=1, ADDR_EDGECAP=3;
  - the EDGE_TYPE encodings.
- One sub-module, pacman_soc_sync_bus: a parameterized WIDTH × SYNC_STAGES synchronizer with synchronous reset.
- Edge logic, registers, arm counter and read mux live in the top module.

## Test plan
- Reset release with in_port=32'hFFFF_FFFF and EDGE_TYPE=0:
  - EDGECAP reads 0 and irq stays 0 for 20 cycles.
  - DATA reads 32'hFFFF_FFFF from the 4th read onward.
- Rising edge with IRQMASK=32'h1:
  - Drive in_port[0] 0→1: irq rises exactly 3 edges later and EDGECAP reads 32'h1.
  - Write 32'h1 to offset 3: irq falls on the next cycle.
- Simultaneous set and clear:
  - A rising edge on bit 4 arrives in the same cycle as a W1C write of 32'h10.
  - EDGECAP bit 4 reads 1 afterwards.
- Mask gating:
  - Capture bits 2 and 5 with IRQMASK=0: irq stays 0.
  - Write IRQMASK=32'h20: irq rises the next cycle.
  - Clear 32'h20: irq falls, while EDGECAP still reads 32'h4.
- EDGE_TYPE=2 with a 2-cycle pulse on bit 7:
  - Both edges are detected, and EDGECAP bit 7 is set.
  - Clearing it between the two edges causes it to re-set on the falling edge.
- Reserved offset and mid-operation reset:
  - Write 32'hDEAD_BEEF to offset 2: it reads 0, and offsets 0, 1 and 3 are unchanged.
  - Assert reset with captures pending: all registers read 0, and irq is 0 the cycle after reset is sampled.
